// File: rtl/hci_outstanding_write_tracker_if.sv
// rtl/hci_outstanding_write_tracker_if.sv - HCI outstanding request/response bundle
interface hci_outstanding_intf #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned BW = 8,
    parameter int unsigned UW = 1,
    parameter int unsigned IW = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    add;
    logic             wen;
    logic [DW/BW-1:0] be;
    logic [DW-1:0]    data;
    logic [UW-1:0]    user;
    logic [IW-1:0]    req_id;

    logic             resp_valid;
    logic             resp_ready;
    logic [DW-1:0]    resp_data;
    logic [UW-1:0]    resp_user;
    logic [IW-1:0]    resp_id;
    logic             resp_opc;

    modport initiator (
        output req_valid, add, wen, be, data, user, req_id,
        input  req_ready,
        input  resp_valid, resp_data, resp_user, resp_id, resp_opc,
        output resp_ready
    );

    modport target (
        input  req_valid, add, wen, be, data, user, req_id,
        output req_ready,
        output resp_valid, resp_data, resp_user, resp_id, resp_opc,
        input  resp_ready
    );
endinterface

// File: rtl/hci_outstanding_write_tracker.sv
// rtl/hci_outstanding_write_tracker.sv - in-flight write cap, ID stamping, in-order response check, drain
module hci_outstanding_write_tracker #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned IW              = 8,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        enable_i,
    hci_outstanding_intf.target         tcdm_target,
    hci_outstanding_intf.initiator      tcdm_initiator,
    input  logic                        drain_req_i,
    output logic                        drain_done_o,
    output logic [CNT_W-1:0]            inflight_o,
    output logic                        idle_o,
    output logic                        err_id_o,
    output logic                        err_unexp_o
);
    typedef enum logic [1:0] {TRK_PASS, TRK_DRAIN, TRK_DONE} trk_state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    trk_state_e       state_q, state_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [IW-1:0]    next_id_q, next_id_d;
    logic [IW-1:0]    exp_id_q, exp_id_d;
    logic             err_id_q, err_id_d;
    logic             err_unexp_q, err_unexp_d;
    logic             drain_done_q;
    logic             accept_ok, req_hs, rsp_hs;

    // Gating uses only registered state so req_valid never waits on req_ready.
    assign accept_ok = (state_q == TRK_PASS) && (inflight_q < MAX_CNT);

    assign tcdm_initiator.req_valid = tcdm_target.req_valid & accept_ok;
    assign tcdm_target.req_ready    = tcdm_initiator.req_ready & accept_ok;
    assign tcdm_initiator.add       = tcdm_target.add;
    assign tcdm_initiator.wen       = tcdm_target.wen;
    assign tcdm_initiator.be        = tcdm_target.be;
    assign tcdm_initiator.data      = tcdm_target.data;
    assign tcdm_initiator.user      = tcdm_target.user;
    assign tcdm_initiator.req_id    = next_id_q;

    assign tcdm_target.resp_valid    = tcdm_initiator.resp_valid;
    assign tcdm_target.resp_data     = tcdm_initiator.resp_data;
    assign tcdm_target.resp_user     = tcdm_initiator.resp_user;
    assign tcdm_target.resp_id       = tcdm_initiator.resp_id;
    assign tcdm_target.resp_opc      = tcdm_initiator.resp_opc;
    assign tcdm_initiator.resp_ready = tcdm_target.resp_ready;

    assign req_hs = tcdm_initiator.req_valid & tcdm_initiator.req_ready;
    assign rsp_hs = tcdm_initiator.resp_valid & tcdm_initiator.resp_ready;

    always_comb begin
        inflight_d  = inflight_q;
        next_id_d   = next_id_q;
        exp_id_d    = exp_id_q;
        err_id_d    = err_id_q;
        err_unexp_d = err_unexp_q;
        if (req_hs && !rsp_hs) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!req_hs && rsp_hs && (inflight_q != '0)) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
        if (req_hs) next_id_d = next_id_q + IW'(1);
        if (rsp_hs) begin
            exp_id_d = exp_id_q + IW'(1);
            if (tcdm_initiator.resp_id != exp_id_q) err_id_d = 1'b1;
            if ((inflight_q == '0) && !req_hs)      err_unexp_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TRK_PASS:  if (drain_req_i)        state_d = TRK_DRAIN;
            TRK_DRAIN: if (inflight_d == '0)   state_d = TRK_DONE;
            TRK_DONE:                          state_d = TRK_PASS;
            default:                           state_d = TRK_PASS;
        endcase
    end

    // drain_done is registered off TRK_DONE, so it follows inflight reaching 0 by one cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q      <= TRK_PASS;
            inflight_q   <= '0;
            next_id_q    <= '0;
            exp_id_q     <= '0;
            err_id_q     <= 1'b0;
            err_unexp_q  <= 1'b0;
            drain_done_q <= 1'b0;
        end else if (enable_i) begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            next_id_q    <= next_id_d;
            exp_id_q     <= exp_id_d;
            err_id_q     <= err_id_d;
            err_unexp_q  <= err_unexp_d;
            drain_done_q <= (state_q == TRK_DONE);
        end
    end

    assign drain_done_o = drain_done_q;
    assign inflight_o   = inflight_q;
    assign idle_o       = (inflight_q == '0);
    assign err_id_o     = err_id_q;
    assign err_unexp_o  = err_unexp_q;
endmodule
